// File: rtl/call_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module  : call_button_conditioner_if
// Brief   : Raw switch inputs and conditioned level/pulse outputs
// Revision: 1.0
// ============================================================================
interface call_button_conditioner_if;
    logic call_raw;
    logic cancel_raw;
    logic call_button;
    logic cancel_button;
    logic call_pulse;
    logic cancel_pulse;

    modport master (
        output call_raw,
        output cancel_raw,
        input  call_button,
        input  cancel_button,
        input  call_pulse,
        input  cancel_pulse
    );

    modport slave (
        input  call_raw,
        input  cancel_raw,
        output call_button,
        output cancel_button,
        output call_pulse,
        output cancel_pulse
    );
endinterface
`default_nettype wire

// File: rtl/call_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : call_button_conditioner
// Brief   : Synchronizes and debounces call/cancel switches, emits press strobes
// Revision: 1.0
// ============================================================================
module call_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    call_button_conditioner_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_PEND_HIGH   = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_PEND_LOW    = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_pulse;

    assign w_raw = {bus.cancel_raw, bus.call_raw};

    // Channel 0 is call, channel 1 is cancel; they share nothing but the clock.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_level;
        logic             r_pulse;
        logic             w_rise;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_state <= ST_STABLE_LOW;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_sync1 <= w_raw[ch];
                r_sync2 <= r_sync1;
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= (w_state_nxt == ST_STABLE_HIGH) || (w_state_nxt == ST_PEND_LOW);
                r_pulse <= w_rise;
            end
        end

        // Count holds the number of agreeing samples already seen while pending.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            w_rise      = 1'b0;
            case (r_state)
                ST_STABLE_LOW: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_PEND_HIGH;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                ST_PEND_HIGH: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_STABLE_LOW;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = ST_STABLE_HIGH;
                        w_rise      = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_STABLE_HIGH: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_PEND_LOW;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                ST_PEND_LOW: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_STABLE_HIGH;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = ST_STABLE_LOW;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE_LOW;
                end
            endcase
        end

        assign w_level[ch] = r_level;
        assign w_pulse[ch] = r_pulse;
    end

    assign bus.call_button   = w_level[0];
    assign bus.cancel_button = w_level[1];
    assign bus.call_pulse    = w_pulse[0];
    assign bus.cancel_pulse  = w_pulse[1];

endmodule
`default_nettype wire

// File: tb/tb_call_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_call_button_conditioner
// Brief   : Bench for call_button_conditioner at DEBOUNCE_CYCLES of 4 and 2
// Revision: 1.0
// ============================================================================
module tb_call_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic call_raw;
    logic cancel_raw;

    always #5 clk = ~clk;

    call_button_conditioner_if bus4 ();
    call_button_conditioner_if bus2 ();

    assign bus4.call_raw   = call_raw;
    assign bus4.cancel_raw = cancel_raw;
    assign bus2.call_raw   = call_raw;
    assign bus2.cancel_raw = cancel_raw;

    call_button_conditioner #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    call_button_conditioner #(.DEBOUNCE_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int checks = 0;
    int passes = 0;

    // Reference: [instance][channel]; instance 0 is D=4, instance 1 is D=2.
    // A level flips once the last D synchronized samples all disagree with it.
    int         deb [2] = '{4, 2};
    bit         m_s1   [2][2];
    bit         m_s2   [2][2];
    bit [255:0] m_hist [2][2];
    bit         m_lvl  [2][2];
    bit         m_pls  [2][2];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d4 call_button",   bus4.call_button,   m_lvl[0][0]);
        chk("d4 cancel_button", bus4.cancel_button, m_lvl[0][1]);
        chk("d4 call_pulse",    bus4.call_pulse,    m_pls[0][0]);
        chk("d4 cancel_pulse",  bus4.cancel_pulse,  m_pls[0][1]);
        chk("d2 call_button",   bus2.call_button,   m_lvl[1][0]);
        chk("d2 cancel_button", bus2.cancel_button, m_lvl[1][1]);
        chk("d2 call_pulse",    bus2.call_pulse,    m_pls[1][0]);
        chk("d2 cancel_pulse",  bus2.cancel_pulse,  m_pls[1][1]);
    endtask

    task automatic tick();
        bit r [2];
        bit rs;
        bit seen;
        bit all_dis;
        r[0] = call_raw;
        r[1] = cancel_raw;
        rs   = reset;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_pls[i][c] = 1'b0;
                if (rs) begin
                    m_s1[i][c]   = 1'b0;
                    m_s2[i][c]   = 1'b0;
                    m_hist[i][c] = '0;
                    m_lvl[i][c]  = 1'b0;
                end else begin
                    seen         = m_s2[i][c];
                    m_s2[i][c]   = m_s1[i][c];
                    m_s1[i][c]   = r[c];
                    m_hist[i][c] = {m_hist[i][c][254:0], seen};
                    all_dis = 1'b1;
                    for (int k = 0; k < deb[i]; k++)
                        if (m_hist[i][c][k] == m_lvl[i][c]) all_dis = 1'b0;
                    if (all_dis) begin
                        m_pls[i][c] = !m_lvl[i][c];
                        m_lvl[i][c] = !m_lvl[i][c];
                    end
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int pulse_cnt;

    initial begin
        reset      = 1'b1;
        call_raw   = 1'b0;
        cancel_raw = 1'b0;
        ticks(2);
        chk("reset call_button",  bus4.call_button,  1'b0);
        chk("reset call_pulse",   bus4.call_pulse,   1'b0);
        chk("reset cancel_button", bus4.cancel_button, 1'b0);
        reset = 1'b0;
        ticks(3);

        // Single press: level and strobe after E0+5 (D=4) and E0+3 (D=2)
        call_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) chk("d2 call_button before E0+3", bus2.call_button, 1'b0);
            if (k == 4) begin
                chk("d2 call_pulse at E0+3", bus2.call_pulse, 1'b1);
                chk("d2 call_button at E0+3", bus2.call_button, 1'b1);
            end
            if (k == 5) chk("d4 call_button before E0+5", bus4.call_button, 1'b0);
            if (k == 6) begin
                chk("d4 call_pulse at E0+5", bus4.call_pulse, 1'b1);
                chk("d4 call_button at E0+5", bus4.call_button, 1'b1);
            end
            if (k == 7) begin
                chk("d4 call_pulse at E0+6", bus4.call_pulse, 1'b0);
                chk("d4 call_button held", bus4.call_button, 1'b1);
            end
        end

        // Two-cycle low glitch while high, then a held release
        call_raw = 1'b0;
        ticks(2);
        call_raw = 1'b1;
        ticks(8);
        chk("d4 call_button after low glitch", bus4.call_button, 1'b1);
        call_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) chk("d4 call_button before release E0+5", bus4.call_button, 1'b1);
            if (k == 6) begin
                chk("d4 call_button released at E0+5", bus4.call_button, 1'b0);
                chk("d4 no pulse on release", bus4.call_pulse, 1'b0);
            end
        end

        // Simultaneous call and cancel presses
        call_raw   = 1'b1;
        cancel_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                chk("d4 both call_pulse", bus4.call_pulse, 1'b1);
                chk("d4 both cancel_pulse", bus4.cancel_pulse, 1'b1);
                chk("d4 both cancel_button", bus4.cancel_button, 1'b1);
            end
        end
        call_raw   = 1'b0;
        cancel_raw = 1'b0;
        ticks(10);

        // Bounce: high 3, low 1, then held high -> exactly one strobe
        pulse_cnt = 0;
        call_raw  = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); pulse_cnt += int'(bus4.call_pulse); end
        call_raw  = 1'b0;
        tick(); pulse_cnt += int'(bus4.call_pulse);
        call_raw  = 1'b1;
        for (int k = 0; k < 20; k++) begin tick(); pulse_cnt += int'(bus4.call_pulse); end
        chk("d4 bounce single pulse", pulse_cnt == 1, 1'b1);

        // Reset while STABLE_HIGH with the button still held
        reset = 1'b1;
        tick();
        chk("mid reset call_button", bus4.call_button, 1'b0);
        chk("mid reset call_pulse", bus4.call_pulse, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("requalify before 6th edge", bus4.call_button, 1'b0);
            if (k == 6) begin
                chk("requalify call_button", bus4.call_button, 1'b1);
                chk("requalify call_pulse", bus4.call_pulse, 1'b1);
            end
        end

        // Randomized bursty toggling with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) call_raw   = ~call_raw;
            if ($urandom_range(0, 5) == 0) cancel_raw = ~cancel_raw;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
